// File: rtl/multiexp_pnt_scl_replay_pkg.sv
// ---------------------------------------------------------------------------
// multiexp_pnt_scl_replay_pkg
//   Shared constants for the G2 multiexp point/scalar replay feeder: default
//   point/scalar widths and key length, and the replay FSM state encoding.
//   Also holds the job-size range check used when a job is accepted.
// ---------------------------------------------------------------------------
package multiexp_pnt_scl_replay_pkg;

   // Default curve/multiexp widths: one beat carries a point and its scalar.
   localparam int DEF_KEY_BITS  = 256;
   localparam int DEF_S_BITS    = DEF_KEY_BITS;
   localparam int DEF_P_BITS    = 768;
   localparam int DEF_P_S_BITS  = DEF_P_BITS + DEF_S_BITS;
   localparam int DEF_DEPTH     = 1024;
   localparam int DEF_CTL_BITS  = 9;
   localparam int DEF_MOD_BITS  = 6;
   localparam int NUM_IN_BITS   = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_REPLAY,
      ST_DRAIN
   } replay_state_t;

   // A job fits the local RAM when it has between 1 and depth points.
   function automatic logic num_in_ok(input logic [NUM_IN_BITS-1:0] num_in,
                                      input int unsigned           depth);
      return (num_in != '0) && (num_in <= NUM_IN_BITS'(depth));
   endfunction

endpackage

// File: rtl/multiexp_pnt_scl_replay_if.sv
// ---------------------------------------------------------------------------
// multiexp_pnt_scl_replay_if
//   AXI-stream style bus used on both sides of the replay feeder.
//   master: drives val/sop/eop/err/dat/mod/ctl, receives rdy.
//   slave : receives val/sop/eop/err/dat/mod/ctl, drives rdy.
//   A beat transfers on a clock edge where val && rdy.
// ---------------------------------------------------------------------------
interface multiexp_pnt_scl_replay_if
   import multiexp_pnt_scl_replay_pkg::*;
#(
   parameter int DAT_BITS = DEF_P_S_BITS,
   parameter int CTL_BITS = DEF_CTL_BITS,
   parameter int MOD_BITS = DEF_MOD_BITS
);

   logic                val;
   logic                rdy;
   logic                sop;
   logic                eop;
   logic                err;
   logic [DAT_BITS-1:0] dat;
   logic [MOD_BITS-1:0] mod;
   logic [CTL_BITS-1:0] ctl;

   modport master (output val, sop, eop, err, dat, mod, ctl, input  rdy);
   modport slave  (input  val, sop, eop, err, dat, mod, ctl, output rdy);

endinterface

// File: rtl/multiexp_replay_ram.sv
// ---------------------------------------------------------------------------
// multiexp_replay_ram
//   Simple dual-port RAM holding one job of point/scalar beats.
//   Ports:
//     i_clk    clock
//     i_we     write enable; i_wdat stored at i_waddr
//     i_re     read enable; o_rdat = RAM[i_raddr] one cycle later
//     o_rdat   registered read data (holds its value when i_re is low)
// ---------------------------------------------------------------------------
module multiexp_replay_ram
   import multiexp_pnt_scl_replay_pkg::*;
#(
   parameter int DAT_BITS = DEF_P_S_BITS,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic                i_clk,
   input  logic                i_we,
   input  logic [AW-1:0]       i_waddr,
   input  logic [DAT_BITS-1:0] i_wdat,
   input  logic                i_re,
   input  logic [AW-1:0]       i_raddr,
   output logic [DAT_BITS-1:0] o_rdat
);

   logic [DAT_BITS-1:0] mem [DEPTH];

   // NOTE: the array has no reset so it maps onto block RAM; every entry
   // read during a job is written earlier in that same job.
   // NOTE: state is updated with non-blocking assignments so all flops
   // sample the pre-edge values, avoiding simulation races.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdat;
      end
      if (i_re) begin
         o_rdat <= mem[i_raddr];
      end
   end

endmodule

// File: rtl/multiexp_pnt_scl_replay.sv
// ---------------------------------------------------------------------------
// multiexp_pnt_scl_replay
//   Upstream feeder for the G2 multiexp top. Captures one job of num_in
//   point/scalar beats into local RAM, then replays the whole set KEY_BITS
//   times in order (one pass per key bit), so the host sends each point once.
//   Ports:
//     i_clk, i_rst_n  clock, asynchronous active-low reset
//     i_num_in        points in the job, sampled when leaving IDLE
//     i_pnt_scl_if    input stream, one pair per beat (sop=eop=1)
//     o_pnt_scl_if    output stream to the multiexp top (sop=eop=1)
//     o_busy          high whenever the FSM is not in IDLE
//     o_err           sticky job-rejected flag, cleared by the next good job
//     o_done          one-cycle pulse after the last replayed beat transfers
// ---------------------------------------------------------------------------
module multiexp_pnt_scl_replay
   import multiexp_pnt_scl_replay_pkg::*;
#(
   parameter int P_S_BITS = DEF_P_S_BITS,
   parameter int KEY_BITS = DEF_KEY_BITS,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int CTL_BITS = DEF_CTL_BITS
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_IN_BITS-1:0] i_num_in,
   multiexp_pnt_scl_replay_if.slave  i_pnt_scl_if,
   multiexp_pnt_scl_replay_if.master o_pnt_scl_if,
   output logic                   o_busy,
   output logic                   o_err,
   output logic                   o_done
);

   localparam int AW     = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int PASS_W = $clog2(KEY_BITS) + 1;
   localparam logic [PASS_W-1:0]   LAST_PASS = PASS_W'(KEY_BITS - 1);
   localparam logic [CTL_BITS-1:0] CTL_ZERO  = '0;

   replay_state_t       state;
   logic                in_rdy;
   logic [CNT_W-1:0]    num_in_q;
   logic [CNT_W-1:0]    last_idx;
   logic [CNT_W-1:0]    wr_cnt;
   logic [CNT_W-1:0]    rd_cnt;
   logic [PASS_W-1:0]   pass_cnt;
   logic                rd_active;   // reads of the current job remain
   logic                rd_vld;      // a RAM read is in flight this cycle
   logic                rd_en;
   logic                in_acc;
   logic                ram_we;
   logic [P_S_BITS-1:0] ram_rdat;

   // 2-entry output FIFO
   logic [P_S_BITS-1:0] fifo_mem [2];
   logic                fifo_wp;
   logic                fifo_rp;
   logic [1:0]          fifo_cnt;
   logic                push;
   logic                pop;
   logic                last_pop;
   logic [2:0]          occ;

   // Input sideband fields carry nothing this block needs.
   logic unused_in;
   assign unused_in = &{1'b0, i_pnt_scl_if.sop, i_pnt_scl_if.err,
                        i_pnt_scl_if.mod, i_pnt_scl_if.ctl};

   assign i_pnt_scl_if.rdy = in_rdy;
   assign in_acc   = i_pnt_scl_if.val && in_rdy;
   assign ram_we   = (state == ST_LOAD) && in_acc;
   assign last_idx = num_in_q - CNT_W'(1);

   assign o_pnt_scl_if.val = (fifo_cnt != 2'd0);
   assign o_pnt_scl_if.dat = fifo_mem[fifo_rp];
   assign o_pnt_scl_if.sop = 1'b1;
   assign o_pnt_scl_if.eop = 1'b1;
   assign o_pnt_scl_if.err = 1'b0;
   assign o_pnt_scl_if.mod = '0;
   assign o_pnt_scl_if.ctl = CTL_ZERO;

   assign push     = rd_vld;
   assign pop      = o_pnt_scl_if.val && o_pnt_scl_if.rdy;
   // Final beat: nothing left to read, nothing in flight, one entry left.
   assign last_pop = pop && !rd_active && !rd_vld && (fifo_cnt == 2'd1);

   // A beat leaving this cycle frees its slot now, which keeps one read in
   // flight per cycle and sustains one beat per clock.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      occ   = '0;
      rd_en = 1'b0;
      occ   = {1'b0, fifo_cnt} + {2'b00, rd_vld} - {2'b00, pop};
      if ((state == ST_REPLAY) && rd_active && (occ < 3'd2)) begin
         rd_en = 1'b1;
      end
   end

   multiexp_replay_ram #(
      .DAT_BITS (P_S_BITS),
      .DEPTH    (DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_waddr (wr_cnt[AW-1:0]),
      .i_wdat  (i_pnt_scl_if.dat),
      .i_re    (rd_en),
      .i_raddr (rd_cnt[AW-1:0]),
      .o_rdat  (ram_rdat)
   );

   // Control FSM with its counters and registered status outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         in_rdy    <= 1'b0;
         o_busy    <= 1'b0;
         o_err     <= 1'b0;
         o_done    <= 1'b0;
         num_in_q  <= '0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         pass_cnt  <= '0;
         rd_active <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_pnt_scl_if.val) begin
                  num_in_q <= i_num_in[CNT_W-1:0];
                  wr_cnt   <= '0;
                  rd_cnt   <= '0;
                  pass_cnt <= '0;
                  in_rdy   <= 1'b1;
                  o_busy   <= 1'b1;
                  if (num_in_ok(i_num_in, DEPTH)) begin
                     o_err <= 1'b0;
                     state <= ST_LOAD;
                  end else begin
                     o_err <= 1'b1;
                     state <= ST_DRAIN;
                  end
               end
            end

            // Rejected job: discard up to and including the next eop.
            ST_DRAIN: begin
               if (in_acc && i_pnt_scl_if.eop) begin
                  in_rdy <= 1'b0;
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end
            end

            ST_LOAD: begin
               if (in_acc) begin
                  if (wr_cnt == last_idx) begin
                     in_rdy    <= 1'b0;
                     rd_active <= 1'b1;
                     state     <= ST_REPLAY;
                  end else begin
                     wr_cnt <= wr_cnt + CNT_W'(1);
                  end
               end
            end

            ST_REPLAY: begin
               if (rd_en) begin
                  if (rd_cnt == last_idx) begin
                     rd_cnt <= '0;
                     if (pass_cnt == LAST_PASS) begin
                        rd_active <= 1'b0;
                     end else begin
                        pass_cnt <= pass_cnt + PASS_W'(1);
                     end
                  end else begin
                     rd_cnt <= rd_cnt + CNT_W'(1);
                  end
               end
               if (last_pop) begin
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read-valid pipeline and FIFO pointers; reset empties the FIFO so the
   // output val drops as soon as reset asserts.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_vld   <= 1'b0;
         fifo_wp  <= 1'b0;
         fifo_rp  <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         rd_vld <= rd_en;
         if (push) begin
            fifo_wp <= ~fifo_wp;
         end
         if (pop) begin
            fifo_rp <= ~fifo_rp;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO payload storage; validity is tracked by fifo_cnt alone.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[fifo_wp] <= ram_rdat;
      end
   end

endmodule

// File: tb/tb_multiexp_pnt_scl_replay.sv
// ---------------------------------------------------------------------------
// tb_multiexp_pnt_scl_replay
//   Directed job sequence with random data and random output back-pressure.
//   Expected output is derived from the job contents: the list of points
//   repeated KEY_BITS times.
// ---------------------------------------------------------------------------
module tb_multiexp_pnt_scl_replay;

   localparam int P_S_BITS = 64;
   localparam int KEY_BITS = 256;
   localparam int DEPTH    = 16;
   localparam int CTL_BITS = 9;
   localparam int MOD_BITS = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] num_in;
   logic        busy;
   logic        err;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [63:0] job_dat [$];
   logic [63:0] exp_q   [$];

   always #5 clk = ~clk;

   multiexp_pnt_scl_replay_if #(.DAT_BITS(P_S_BITS), .CTL_BITS(CTL_BITS),
                                .MOD_BITS(MOD_BITS)) in_if ();
   multiexp_pnt_scl_replay_if #(.DAT_BITS(P_S_BITS), .CTL_BITS(CTL_BITS),
                                .MOD_BITS(MOD_BITS)) out_if ();

   multiexp_pnt_scl_replay #(
      .P_S_BITS (P_S_BITS),
      .KEY_BITS (KEY_BITS),
      .DEPTH    (DEPTH),
      .CTL_BITS (CTL_BITS)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_num_in     (num_in),
      .i_pnt_scl_if (in_if),
      .o_pnt_scl_if (out_if),
      .o_busy       (busy),
      .o_err        (err),
      .o_done       (done)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_job(input int n);
      job_dat.delete();
      for (int i = 0; i < n; i++) begin
         job_dat.push_back({$urandom(), $urandom()});
      end
   endtask

   // Reference: the job's points in order, once per key bit.
   task automatic build_expect(input int n);
      exp_q.delete();
      for (int p = 0; p < KEY_BITS; p++) begin
         for (int i = 0; i < n; i++) begin
            exp_q.push_back(job_dat[i]);
         end
      end
   endtask

   // Offer cnt beats of job_dat with num_in held at num; returns at posedge+1.
   task automatic send_job(input logic [63:0] num, input int cnt);
      int k;
      int cyc;
      bit acc;
      k      = 0;
      cyc    = 0;
      num_in = num;
      while (k < cnt && cyc < 8 * cnt + 40) begin
         in_if.val = 1'b1;
         in_if.dat = job_dat[k];
         in_if.sop = 1'b1;
         in_if.eop = 1'b1;
         @(negedge clk);
         acc = in_if.rdy;
         check("no_out_during_load", {63'd0, out_if.val}, 64'd0);
         @(posedge clk);
         #1;
         if (acc) k++;
         cyc++;
      end
      in_if.val = 1'b0;
      check("beats_accepted", 64'(k), 64'(cnt));
   endtask

   // Collect replayed beats against exp_q. stall_pct = % of cycles with
   // rdy low. stop_after >= 0 returns at the negedge after that many beats.
   task automatic recv_job(input int stall_pct, input int stop_after);
      int got;
      int cyc;
      int done_cnt;
      int bound;
      bit stalled;
      bit seen;
      logic [63:0] held;
      got      = 0;
      cyc      = 0;
      done_cnt = 0;
      stalled  = 1'b0;
      seen     = 1'b0;
      held     = '0;
      bound    = exp_q.size() * 4 + 50;
      while (cyc < bound) begin
         out_if.rdy = (stall_pct == 0) ? 1'b1
                                       : ($urandom_range(99) >= stall_pct);
         // Offer junk input and wiggle num_in while replay runs.
         in_if.val = (exp_q.size() > 4);
         in_if.dat = 64'hDEAD_BEEF_0BAD_F00D;
         num_in    = {$urandom(), $urandom()};
         @(negedge clk);
         if (done) done_cnt++;
         if (stalled) begin
            check("stall_val_held", {63'd0, out_if.val}, 64'd1);
            check("stall_dat_held", out_if.dat, held);
         end
         if (stall_pct == 0 && seen && exp_q.size() != 0)
            check("no_gap", {63'd0, out_if.val}, 64'd1);
         if (in_if.val)
            check("input_held_off", {63'd0, in_if.rdy}, 64'd0);
         if (out_if.val && out_if.rdy) begin
            if (!seen)
               check("out_sideband", {61'd0, out_if.sop, out_if.eop, out_if.err},
                     64'b110);
            if (exp_q.size() == 0) begin
               check("extra_beat", {63'd0, out_if.val}, 64'd0);
            end else begin
               check("beat_dat", out_if.dat, exp_q.pop_front());
               got++;
            end
            seen = 1'b1;
         end
         stalled = out_if.val && !out_if.rdy;
         held    = out_if.dat;
         if (done_cnt != 0) break;
         if (stop_after >= 0 && got == stop_after) break;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_if.val = 1'b0;
      if (stop_after < 0) begin
         check("all_beats_out", 64'(exp_q.size()), 64'd0);
         check("done_pulses", 64'(done_cnt), 64'd1);
         repeat (3) begin
            @(posedge clk);
            #1;
            out_if.rdy = 1'b1;
            @(negedge clk);
            check("idle_no_val", {63'd0, out_if.val}, 64'd0);
            check("done_single", {63'd0, done}, 64'd0);
         end
         check("busy_after", {63'd0, busy}, 64'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      num_in     = '0;
      in_if.val  = 1'b0;
      in_if.sop  = 1'b0;
      in_if.eop  = 1'b0;
      in_if.err  = 1'b0;
      in_if.dat  = '0;
      in_if.mod  = '0;
      in_if.ctl  = '0;
      out_if.rdy = 1'b0;
      #1;
      check("rst_out_val", {63'd0, out_if.val}, 64'd0);
      check("rst_in_rdy",  {63'd0, in_if.rdy},  64'd0);
      check("rst_busy",    {63'd0, busy},       64'd0);
      check("rst_err",     {63'd0, err},        64'd0);
      check("rst_done",    {63'd0, done},       64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Job A,B,C,D with downstream always ready.
      job_dat.delete();
      job_dat.push_back(64'hAAAA_0000_0000_000A);
      job_dat.push_back(64'hBBBB_0000_0000_000B);
      job_dat.push_back(64'hCCCC_0000_0000_000C);
      job_dat.push_back(64'hDDDD_0000_0000_000D);
      build_expect(4);
      send_job(64'd4, 4);
      check("busy_in_replay", {63'd0, busy}, 64'd1);
      check("err_good_job", {63'd0, err}, 64'd0);
      recv_job(0, -1);

      // Same job with ~30% output stalls.
      build_expect(4);
      send_job(64'd4, 4);
      recv_job(30, -1);

      // Single-point job: KEY_BITS back-to-back copies.
      fill_job(1);
      build_expect(1);
      send_job(64'd1, 1);
      recv_job(0, -1);

      // Full-depth job, with stalls.
      fill_job(DEPTH);
      build_expect(DEPTH);
      send_job(64'(DEPTH), DEPTH);
      recv_job(30, -1);

      // Oversized job: rejected and drained, no output.
      fill_job(DEPTH + 1);
      send_job(64'(DEPTH + 1), DEPTH + 1);
      check("err_oversize", {63'd0, err}, 64'd1);
      check("busy_after_drain", {63'd0, busy}, 64'd0);

      // Next good job clears the error.
      fill_job(2);
      build_expect(2);
      send_job(64'd2, 2);
      check("err_cleared", {63'd0, err}, 64'd0);
      recv_job(0, -1);

      // Empty job: rejected.
      fill_job(1);
      send_job(64'd0, 1);
      check("err_zero", {63'd0, err}, 64'd1);
      check("busy_after_zero", {63'd0, busy}, 64'd0);

      // Reset during pass 2 of a replay.
      fill_job(4);
      build_expect(4);
      send_job(64'd4, 4);
      recv_job(0, 9);
      rst_n = 1'b0;
      #1;
      check("midrst_val",    {63'd0, out_if.val}, 64'd0);
      check("midrst_busy",   {63'd0, busy},       64'd0);
      check("midrst_in_rdy", {63'd0, in_if.rdy},  64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fresh job after reset must carry only new data.
      fill_job(3);
      build_expect(3);
      send_job(64'd3, 3);
      recv_job(0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
